// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register with synchronous flush and flushed-entry counter.
// The main register drives out_data; the skid register catches one extra entry
// so in_ready can come straight from a flop without losing data under backpressure.

// Property checker: watches the observable handshake and data-stability rules.
module pipe_skid_reg_chk #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  input logic              in_ready,
  input logic              out_valid,
  input logic              out_ready,
  input logic [DATA_W-1:0] out_data,
  input logic [1:0]        occupancy
);

  // Occupancy never encodes more than two held entries.
  a_occ_range: assert property (@(posedge clk) disable iff (!reset)
    occupancy != 2'd3);

  // out_valid mirrors a non-zero occupancy.
  a_valid_occ: assert property (@(posedge clk) disable iff (!reset)
    out_valid == (occupancy != 2'd0));

  // Empty output always presents the reset value.
  a_empty_data: assert property (@(posedge clk) disable iff (!reset)
    !out_valid |-> (out_data == RST_VAL));

  // A full block never advertises readiness.
  a_full_not_ready: assert property (@(posedge clk) disable iff (!reset)
    (occupancy == 2'd2) |-> !in_ready);

  // A stalled valid output holds until the consumer takes it or a flush.
  a_hold_stall: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

module pipe_skid_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Saturating add of a small discard count onto the flush counter.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [1:0]       b
  );
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
    if (sum > {2'b00, {CNT_W{1'b1}}}) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  state_e              r_state;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic                r_main_vld;
  logic                r_skid_vld;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_flush_cnt;

  state_e              w_state_nxt;
  logic [DATA_W-1:0]   w_main_nxt;
  logic [DATA_W-1:0]   w_skid_nxt;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [1:0]          w_occ;
  logic [1:0]          w_flush_add;
  logic [CNT_W-1:0]    w_flush_cnt_nxt;

  // Outputs come straight from flops; occupancy is decoded from the two valid bits.
  assign in_ready  = r_in_ready;
  assign out_valid = r_main_vld;
  assign out_data  = r_main;
  assign w_occ     = {r_skid_vld, r_main_vld & ~r_skid_vld};
  assign occupancy = w_occ;
  assign flush_cnt = r_flush_cnt;

  // Next-state and next-data decode; flush overrides every handshake.
  always_comb begin
    w_in_fire   = in_valid & r_in_ready;
    w_out_fire  = r_main_vld & out_ready;
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = in_data;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = RST_VAL;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = RST_VAL;
          end else begin
            w_state_nxt = ST_TWO;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = RST_VAL;
          w_skid_nxt  = RST_VAL;
        end
      endcase
    end
  end

  // Discard count for a flush: held entries minus one that leaves in the same edge.
  always_comb begin
    w_flush_add     = w_occ - {1'b0, w_out_fire};
    w_flush_cnt_nxt = r_flush_cnt;
    if (flush) begin
      w_flush_cnt_nxt = sat_add(r_flush_cnt, w_flush_add);
    end else begin
      w_flush_cnt_nxt = r_flush_cnt;
    end
  end

  // State register with the per-register valid bits derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_main_vld <= (w_state_nxt != ST_EMPTY);
      r_skid_vld <= (w_state_nxt == ST_TWO);
    end
  end

  // Payload registers: main feeds out_data, skid holds the overflow entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= RST_VAL;
      r_skid <= RST_VAL;
    end else begin
      r_main <= w_main_nxt;
      r_skid <= w_skid_nxt;
    end
  end

  // Registered ready: low through reset, then high unless the next state is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // Flushed-entry counter; reset clears it, flush adds with saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  pipe_skid_reg_chk #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: table vectors, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] RV = 16'hDEAD;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;

  logic          in_ready,  s_in_ready;
  logic          out_valid, s_out_valid;
  logic [DW-1:0] out_data,  s_out_data;
  logic [1:0]    occupancy, s_occupancy;
  logic [7:0]    flush_cnt;
  logic [1:0]    s_flush_cnt;

  pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .occupancy(occupancy),
    .flush_cnt(flush_cnt)
  );

  pipe_skid_reg #(.DATA_W(DW), .RST_VAL(RV), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .flush(flush), .occupancy(s_occupancy),
    .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO of held entries, registered ready, total discards.
  logic [DW-1:0] mq[$];
  bit            m_rdy;
  int            m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic iv, input logic [DW-1:0] id,
                            input logic ordy, input logic fl);
    bit inf, outf;
    inf  = iv && m_rdy;
    outf = (mq.size() > 0) && ordy;
    if (fl) begin
      m_cnt = m_cnt + mq.size() - (outf ? 1 : 0);
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(id);
      m_rdy = (mq.size() < 2);
    end
  endtask

  task automatic model_check(input string tag);
    logic [DW-1:0] ed;
    int sz;
    sz = mq.size();
    ed = (sz > 0) ? mq[0] : RV;
    chk({tag, "_out_valid"}, out_valid, (sz > 0));
    chk({tag, "_out_data"},  out_data,  ed);
    chk({tag, "_occupancy"}, occupancy, sz);
    chk({tag, "_in_ready"},  in_ready,  m_rdy);
    chk({tag, "_flush_cnt"}, flush_cnt, (m_cnt > 255) ? 255 : m_cnt);
    chk({tag, "_sat_cnt"},   s_flush_cnt, (m_cnt > 3) ? 3 : m_cnt);
    chk({tag, "_sat_data"},  s_out_data, ed);
    chk({tag, "_sat_rdy"},   s_in_ready, m_rdy);
    chk({tag, "_sat_occ"},   s_occupancy, sz);
    chk({tag, "_sat_vld"},   s_out_valid, (sz > 0));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic cycle(input string tag, input logic iv, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge(iv, id, ordy, fl);
    #1;
    model_check(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  RV);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_flush_cnt", flush_cnt, 0);
    #2 reset = 1'b1;
    // First edge after release: in_ready is still low so this offer is not taken.
    cycle("rel", 1'b1, 16'h0BAD, 1'b0, 1'b0);
    chk("rel_in_ready_up", in_ready, 1);
    chk("rel_no_accept", out_valid, 0);
  endtask

  typedef struct {
    logic iv; logic [DW-1:0] id; logic ordy; logic fl;
    logic ev; logic [DW-1:0] ed; logic [1:0] eo; logic er; int ec;
  } vec_t;

  vec_t tbl[15];
  int   exp_sat[3];
  int   exp_main[3];

  initial begin
    //           iv    id        ordy  fl    ev    ed        eo     er    ec
    tbl[0]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd1, 1'b1, 0};
    tbl[1]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0, 0};
    tbl[2]  = '{1'b1, 16'h000C, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0, 0};
    tbl[3]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000B, 2'd1, 1'b1, 0};
    tbl[4]  = '{1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, 16'h000C, 2'd1, 1'b1, 0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, RV,       2'd0, 1'b1, 0};
    tbl[6]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1, 0};
    tbl[7]  = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'h0011, 2'd2, 1'b0, 0};
    tbl[8]  = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, RV,       2'd0, 1'b1, 2};
    tbl[9]  = '{1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 16'h0044, 2'd1, 1'b1, 2};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, RV,       2'd0, 1'b1, 2};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, RV,       2'd0, 1'b1, 2};
    tbl[12] = '{1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, RV,       2'd0, 1'b1, 2};
    tbl[13] = '{1'b1, 16'h0066, 1'b0, 1'b0, 1'b1, 16'h0066, 2'd1, 1'b1, 2};
    tbl[14] = '{1'b1, 16'h0077, 1'b0, 1'b1, 1'b0, RV,       2'd0, 1'b1, 3};
    exp_sat  = '{2, 3, 3};
    exp_main = '{2, 4, 6};

    do_reset();

    // Streaming at full rate: each value appears one cycle after it is offered.
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1'b1, DW'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d_data", i), out_data, i);
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_occ", i), occupancy, 1);
      chk($sformatf("stream%0d_rdy", i), in_ready, 1);
    end
    cycle("drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure, flush in TWO, flush with out_fire, flush while EMPTY.
    for (int i = 0; i < 15; i++) begin
      cycle($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("row%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("row%0d_data", i),  out_data,  tbl[i].ed);
      chk($sformatf("row%0d_occ", i),   occupancy, tbl[i].eo);
      chk($sformatf("row%0d_rdy", i),   in_ready,  tbl[i].er);
      chk($sformatf("row%0d_cnt", i),   flush_cnt, tbl[i].ec);
      chk($sformatf("row%0d_satcnt", i), s_flush_cnt, (tbl[i].ec > 3) ? 3 : tbl[i].ec);
    end

    // Saturation: three flushes from TWO on a fresh 2-bit counter.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle("sat_fill", 1'b1, DW'(16'h0100 + k), 1'b0, 1'b0);
      cycle("sat_fill", 1'b1, DW'(16'h0200 + k), 1'b0, 1'b0);
      chk($sformatf("sat%0d_full", k), occupancy, 2);
      cycle("sat_flush", 1'b0, 16'h0000, 1'b0, 1'b1);
      chk($sformatf("sat%0d_cnt2", k), s_flush_cnt, exp_sat[k]);
      chk($sformatf("sat%0d_cnt8", k), flush_cnt, exp_main[k]);
    end

    // Asynchronous reset mid-cycle while full.
    cycle("ar_fill", 1'b1, 16'h0AAA, 1'b0, 1'b0);
    cycle("ar_fill", 1'b1, 16'h0BBB, 1'b0, 1'b0);
    chk("ar_full", occupancy, 2);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data",  out_data,  RV);
    chk("ar_occ",       occupancy, 0);
    chk("ar_in_ready",  in_ready,  0);
    chk("ar_flush_cnt", flush_cnt, 0);
    chk("ar_sat_cnt",   s_flush_cnt, 0);
    @(posedge clk);
    #1;
    chk("ar_hold_rdy", in_ready, 0);
    #2 reset = 1'b1;
    cycle("ar_rel", 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ar_rel_rdy", in_ready, 1);
    cycle("ar_post", 1'b1, 16'h0099, 1'b1, 1'b0);
    chk("ar_post_data", out_data, 16'h0099);

    // Random traffic with varying backpressure and occasional flush.
    for (int c = 0; c < 3000; c++) begin
      logic iv, ordy, fl;
      int bias;
      bias = (c / 250) % 3;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (bias == 0) ? 1'b1 : (bias == 1) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 1) == 1);
      fl   = ($urandom_range(0, 24) == 0);
      cycle("rnd", iv, DW'($urandom), ordy, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, width of one pipeline payload (e.g. {PC, instruction}).
REQ-002 Parameter RST_VAL, default 0 (DATA_W bits), value out_data holds after reset, after flush and while empty.
REQ-003 Parameter CNT_W, default 8, width of the flushed-entry counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; reset is asserted when this port is 0.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle; driven directly from a flop.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_W  oldest held entry; registered output.
REQ-012 flush  input  1  synchronous; discards all held entries.
REQ-013 occupancy  output  2  number of held entries, 0..2.
REQ-014 flush_cnt  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-015 Storage SHALL be a main register (drives out_data) and a skid register, each with its own valid bit; there is no other data storage.
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both are evaluated at the rising edge.
REQ-017 State SHALL be EMPTY (occupancy 0), ONE (1) or TWO (2); out_valid = (state != EMPTY); in_ready = (state != TWO), registered.
REQ-018 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay EMPTY.
REQ-019 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire only -> TWO, skid <= in_data; out_fire only -> EMPTY, main <= RST_VAL; neither -> hold.
REQ-020 TWO: out_fire -> ONE, main <= skid, skid <= RST_VAL; otherwise hold. in_valid is ignored because in_ready = 0.
REQ-021 Latency: an entry accepted at edge N SHALL appear on out_data with out_valid = 1 after edge N, i.e. in cycle N+1.
REQ-022 Throughput: with out_ready held at 1, one entry SHALL be accepted and one delivered every cycle, and the block never enters TWO.
REQ-023 Order: entries SHALL leave in acceptance order, with no loss or duplication except by flush.
REQ-024 Flush has priority over every handshake. At the edge it is sampled, the block SHALL go to EMPTY, set main and skid to RST_VAL, and set in_ready to 1. A simultaneous in_fire is dropped; a simultaneous out_fire counts as delivered.
REQ-025 At that edge, flush_cnt SHALL add the pre-flush occupancy minus 1 if out_fire also occurred, saturating at 2^CNT_W-1 with no wrap.
REQ-026 A flush while EMPTY SHALL leave flush_cnt unchanged.
REQ-027 While out_valid = 0, out_data SHALL equal RST_VAL.
REQ-028 out_valid and out_data SHALL stay stable while out_valid = 1 and out_ready = 0, until flush or reset.

Reset
REQ-029 While reset = 0, asynchronously and regardless of clk: state EMPTY, main = skid = RST_VAL, out_valid = 0, occupancy = 0, flush_cnt = 0.
REQ-030 During reset assertion, in_ready SHALL be 0.
REQ-031 in_ready SHALL go to 1 at the first rising edge after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all entries without incrementing flush_cnt.
REQ-033 The first in_fire possible is at the second rising edge after reset deassertion.

Verification
REQ-034 Streaming: out_ready = 1, send 0x1..0x8 on consecutive cycles -> out_data is 0x1..0x8 on consecutive cycles, one cycle late; occupancy never exceeds 1.
REQ-035 Backpressure: out_ready = 0, send 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready = 0 with 0xC stalled, occupancy = 2; raise out_ready -> 0xA, 0xB, 0xC delivered in order.
REQ-036 Flush in TWO with out_ready = 0 and in_valid = 1 -> occupancy 0, out_valid 0, out_data = RST_VAL, in_ready 1, flush_cnt +2, pending input dropped.
REQ-037 Flush in ONE with out_fire in the same cycle -> flush_cnt unchanged; flush while EMPTY -> flush_cnt unchanged.
REQ-038 Saturation: CNT_W = 2, three flushes in state TWO -> flush_cnt reads 2, then 3, then 3.
REQ-039 Asynchronous reset: drive reset = 0 mid-cycle while in TWO -> outputs reach reset values before the next clk edge, flush_cnt = 0; after release, in_ready = 1 after the first edge.
